// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Grants a shared serial bus to one of two masters (round-robin), then
//   tracks the transaction on the muxed serial lines until it completes,
//   times out or is abandoned. A one-cycle DONE state with both grants low
//   separates consecutive grants.
//
// Ports
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-high reset
//   breq1   in   bus request, master 1 (held until transaction done)
//   breq2   in   bus request, master 2
//   mvalid  in   muxed master valid, one address/data bit per high cycle
//   smode   in   muxed master mode (1 write, 0 read), taken with first mvalid
//   svalid  in   slave read-data valid, one bit per high cycle
//   sready  in   selected slave ready (write acknowledge)
//   bgrant1 out  registered grant, master 1
//   bgrant2 out  registered grant, master 2
//   msel    out  bus mux select (0 master 1, 1 master 2), holds last grantee
//   busy    out  high whenever the controller is not idle
module bus_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic breq1,
  input  logic breq2,
  input  logic mvalid,
  input  logic smode,
  input  logic svalid,
  input  logic sready,
  output logic bgrant1,
  output logic bgrant2,
  output logic msel,
  output logic busy
);

  localparam int MAXW  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W = $clog2(MAXW + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [7:0]       TMO_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_WAIT_ACK,
    S_WAIT_RD,
    S_RDATA,
    S_DONE
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]       r_tmr, w_tmr_nxt;
  logic             r_mode, w_mode_nxt;
  logic             r_last_m2, w_last_m2_nxt;  // 1: master 2 was served last
  logic             r_bgrant1, w_bgrant1_nxt;
  logic             r_bgrant2, w_bgrant2_nxt;
  logic             r_msel, w_msel_nxt;

  logic w_progress;
  logic w_timed;
  logic w_breq_g;
  logic w_tmo;
  logic w_pick2;
  logic w_addr_mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_tmr     <= '0;
      r_mode    <= 1'b0;
      r_last_m2 <= 1'b1;
      r_bgrant1 <= 1'b0;
      r_bgrant2 <= 1'b0;
      r_msel    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_tmr     <= w_tmr_nxt;
      r_mode    <= w_mode_nxt;
      r_last_m2 <= w_last_m2_nxt;
      r_bgrant1 <= w_bgrant1_nxt;
      r_bgrant2 <= w_bgrant2_nxt;
      r_msel    <= w_msel_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_tmr_nxt     = r_tmr;
    w_mode_nxt    = r_mode;
    w_last_m2_nxt = r_last_m2;
    w_bgrant1_nxt = r_bgrant1;
    w_bgrant2_nxt = r_bgrant2;
    w_msel_nxt    = r_msel;
    w_progress    = 1'b0;
    w_timed       = 1'b0;

    w_breq_g    = r_msel ? breq2 : breq1;
    w_tmo       = (r_tmr == TMO_LAST);
    // Master 2 wins if it is the only requester, or on a tie when master 1
    // was served last.
    w_pick2     = breq2 & (~breq1 | ~r_last_m2);
    // On the first address bit the mode is still on the bus, not latched.
    w_addr_mode = (r_cnt == '0) ? smode : r_mode;

    case (r_state)
      S_IDLE: begin
        if (breq1 | breq2) begin
          w_state_nxt   = S_ADDR;
          w_bgrant1_nxt = ~w_pick2;
          w_bgrant2_nxt = w_pick2;
          w_msel_nxt    = w_pick2;
        end
      end
      S_ADDR: begin
        w_timed = 1'b1;
        if (mvalid) begin
          w_progress = 1'b1;
          if (r_cnt == '0) w_mode_nxt = smode;
          if (r_cnt == ADDR_LAST) w_state_nxt = w_addr_mode ? S_WDATA : S_WAIT_RD;
        end else if ((r_cnt == '0) && !w_breq_g) begin
          // Request withdrawn before any address bit: abandon the grant.
          w_state_nxt = S_DONE;
        end else if (w_tmo) begin
          w_state_nxt = S_DONE;
        end
      end
      S_WDATA: begin
        w_timed = 1'b1;
        if (mvalid) begin
          w_progress = 1'b1;
          if (r_cnt == DATA_LAST) w_state_nxt = S_WAIT_ACK;
        end else if (w_tmo) begin
          w_state_nxt = S_DONE;
        end
      end
      S_WAIT_ACK: begin
        w_timed = 1'b1;
        if (sready) begin
          w_progress  = 1'b1;
          w_state_nxt = S_DONE;
        end else if (w_tmo) begin
          w_state_nxt = S_DONE;
        end
      end
      S_WAIT_RD: begin
        w_timed = 1'b1;
        if (svalid) begin
          w_progress  = 1'b1;
          w_state_nxt = (DATA_WIDTH == 1) ? S_DONE : S_RDATA;
        end else if (w_tmo) begin
          w_state_nxt = S_DONE;
        end
      end
      S_RDATA: begin
        if (svalid) begin
          w_progress = 1'b1;
          if (r_cnt == DATA_LAST) w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_last_m2_nxt = r_msel;
        w_state_nxt   = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_state_nxt == S_DONE) begin
      w_bgrant1_nxt = 1'b0;
      w_bgrant2_nxt = 1'b0;
    end

    // Counters restart on any state change. The bit that moves WAIT_RD into
    // RDATA is already read bit 1, so RDATA starts counting from one.
    if (w_state_nxt != r_state) begin
      w_cnt_nxt = (w_state_nxt == S_RDATA) ? CNT_W'(1) : '0;
      w_tmr_nxt = '0;
    end else if (w_progress) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
      w_tmr_nxt = '0;
    end else if (w_timed) begin
      w_tmr_nxt = r_tmr + 8'd1;
    end
  end

  assign bgrant1 = r_bgrant1;
  assign bgrant2 = r_bgrant2;
  assign msel    = r_msel;
  assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: random transactions per round, expected grant
// owner / grant timing / grant length queued at issue time and checked by an
// independent monitor as grants appear and drop.
module tb_bus_arbiter;

  localparam int A      = 12;
  localparam int D      = 8;
  localparam int TMO    = 255;
  localparam int NTRANS = 40;
  localparam int RST_T  = 5;

  localparam int K_WR      = 0;
  localparam int K_RD      = 1;
  localparam int K_ABORT   = 2;
  localparam int K_LATEDRP = 3;
  localparam int K_TMO_A   = 4;
  localparam int K_TMO_ACK = 5;

  logic clk = 1'b0;
  logic rst, breq1, breq2, mvalid, smode, svalid, sready;
  logic bgrant1, bgrant2, msel, busy;

  bus_arbiter #(.ADDR_WIDTH(A), .DATA_WIDTH(D), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .breq1(breq1), .breq2(breq2),
    .mvalid(mvalid), .smode(smode), .svalid(svalid), .sready(sready),
    .bgrant1(bgrant1), .bgrant2(bgrant2), .msel(msel), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {logic mv; logic sm; logic sv; logic sr; logic dr;} item_t;
  typedef struct {int master; int cyc; int len; bit aborted;} exp_t;

  item_t items[$];
  exp_t  sb[$];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic add(input logic mv, input logic sm, input logic sv, input logic sr, input logic dr);
    item_t it;
    it.mv = mv; it.sm = sm; it.sv = sv; it.sr = sr; it.dr = dr;
    items.push_back(it);
  endtask

  // n master bits with 0..2 idle cycles before each; the first address bit
  // carries the real mode, later bits carry junk mode.
  task automatic gen_bits(input int n, input bit is_addr, input logic mode);
    for (int i = 0; i < n; i++) begin
      int g;
      g = $urandom_range(0, 2);
      for (int j = 0; j < g; j++) add(1'b0, rb(), rb(), rb(), 1'b0);
      add(1'b1, (is_addr && i == 0) ? mode : rb(), rb(), rb(), 1'b0);
    end
  endtask

  task automatic build(input int kind);
    int w;
    int first;
    items.delete();
    case (kind)
      K_WR, K_LATEDRP, K_TMO_ACK: begin
        gen_bits(A, 1'b1, 1'b1);
        gen_bits(D, 1'b0, 1'b0);
        w = (kind == K_TMO_ACK) ? TMO : $urandom_range(0, 3);
        for (int j = 0; j < w; j++) add(rb(), rb(), rb(), 1'b0, 1'b0);
        if (kind != K_TMO_ACK) add(rb(), rb(), rb(), 1'b1, 1'b0);
        if (kind == K_LATEDRP) begin
          first = -1;
          for (int i = 0; i < items.size(); i++) begin
            if (first < 0 && items[i].mv) first = i;
            else if (first >= 0) items[i].dr = 1'b1;
          end
        end
      end
      K_RD: begin
        gen_bits(A, 1'b1, 1'b0);
        w = $urandom_range(0, 3);
        for (int j = 0; j < w; j++) add(rb(), rb(), 1'b0, rb(), 1'b0);
        add(rb(), rb(), 1'b1, rb(), 1'b0);
        for (int i = 1; i < D; i++) begin
          w = $urandom_range(0, 2);
          for (int j = 0; j < w; j++) add(rb(), rb(), 1'b0, rb(), 1'b0);
          add(rb(), rb(), 1'b1, rb(), 1'b0);
        end
      end
      K_ABORT: begin
        w = $urandom_range(0, 3);
        for (int j = 0; j < w; j++) add(1'b0, rb(), rb(), rb(), 1'b0);
        add(1'b0, rb(), rb(), rb(), 1'b1);
      end
      default: begin
        for (int j = 0; j < TMO; j++) add(1'b0, rb(), rb(), rb(), 1'b0);
      end
    endcase
  endtask

  // Monitor: pops one expectation per grant and checks owner, timing,
  // length, the DONE gap and the idle state after it.
  initial begin
    int   phase;
    int   len;
    int   gm;
    exp_t cur;
    phase = 0;
    len = 0;
    cur = '{master: 1, cyc: 0, len: 0, aborted: 1'b0};
    forever begin
      @(negedge clk);
      if (rst) begin
        phase = 0;
        continue;
      end
      check("grant_mutex", int'(bgrant1 & bgrant2), 0);
      case (phase)
        0: if (bgrant1 | bgrant2) begin
          gm = bgrant2 ? 2 : 1;
          if (sb.size() == 0) begin
            check("unexpected_grant", gm, 0);
          end else begin
            cur = sb.pop_front();
            check("grant_master", gm, cur.master);
            check("grant_cycle", cyc, cur.cyc);
            check("msel_at_grant", int'(msel), cur.master - 1);
            len = 1;
            phase = 1;
          end
        end
        1: if (bgrant1 | bgrant2) begin
          len++;
          check("owner_stable", bgrant2 ? 2 : 1, cur.master);
        end else begin
          check("busy_in_done", int'(busy), 1);
          if (!cur.aborted) check("grant_len", len, cur.len);
          phase = 2;
        end
        default: begin
          check("busy_after_done", int'(busy), 0);
          check("msel_hold", int'(msel), cur.master - 1);
          phase = 0;
        end
      endcase
    end
  end

  // Driver and transaction-level reference model.
  initial begin
    int r1, r2, win, kind, mvcnt, last;
    bit pend1, pend2, post_reset, aborted;
    rst = 1'b1; breq1 = 1'b0; breq2 = 1'b0;
    mvalid = 1'b0; smode = 1'b0; svalid = 1'b0; sready = 1'b0;
    repeat (2) @(negedge clk);
    check("por_bgrant1", int'(bgrant1), 0);
    check("por_bgrant2", int'(bgrant2), 0);
    check("por_msel", int'(msel), 0);
    check("por_busy", int'(busy), 0);
    #2 rst = 1'b0;
    last = 2; pend1 = 1'b0; pend2 = 1'b0; post_reset = 1'b0;

    for (int t = 0; t < NTRANS; t++) begin
      r1 = int'(pend1) | int'(rb());
      r2 = int'(pend2) | int'(rb());
      if (t == 0) begin r1 = 1; r2 = 1; end
      if (post_reset) begin r1 = 0; r2 = 1; post_reset = 1'b0; end
      if (r1 == 0 && r2 == 0) r1 = 1;
      win = (r1 != 0 && r2 != 0) ? ((last == 1) ? 2 : 1) : ((r1 != 0) ? 1 : 2);

      if (t == 0 || t == RST_T) kind = K_WR;
      else if (t == 10 || t == 25) kind = K_TMO_A;
      else if (t == 18) kind = K_TMO_ACK;
      else kind = $urandom_range(0, 3);
      build(kind);

      sb.push_back('{master: win, cyc: cyc + 1, len: items.size(), aborted: (t == RST_T)});
      breq1 = (r1 != 0);
      breq2 = (r2 != 0);
      @(negedge clk);

      mvcnt = 0;
      aborted = 1'b0;
      for (int i = 0; i < items.size(); i++) begin
        if (t == RST_T && mvcnt == A + 3) begin
          // Mid write-data: reset between edges, outputs must drop at once.
          #2 rst = 1'b1;
          breq1 = 1'b0; breq2 = 1'b0;
          mvalid = 1'b0; svalid = 1'b0; sready = 1'b0;
          #1;
          check("rst_bgrant1", int'(bgrant1), 0);
          check("rst_bgrant2", int'(bgrant2), 0);
          check("rst_msel", int'(msel), 0);
          check("rst_busy", int'(busy), 0);
          @(negedge clk);
          @(negedge clk);
          #2 rst = 1'b0;
          aborted = 1'b1;
          break;
        end
        mvalid = items[i].mv;
        smode  = items[i].sm;
        svalid = items[i].sv;
        sready = items[i].sr;
        if (win == 1) breq1 = ~items[i].dr;
        else          breq2 = ~items[i].dr;
        if (items[i].mv) mvcnt++;
        @(negedge clk);
      end

      if (aborted) begin
        post_reset = 1'b1;
        last = 2;
        pend1 = 1'b0;
        pend2 = 1'b0;
      end else begin
        mvalid = 1'b0; svalid = 1'b0; sready = 1'b0;
        if (win == 1) breq1 = 1'b0;
        else          breq2 = 1'b0;
        pend1 = (win == 2) && (r1 != 0);
        pend2 = (win == 1) && (r2 != 0);
        last = win;
        @(negedge clk);
      end
    end

    breq1 = 1'b0;
    breq2 = 1'b0;
    repeat (4) @(negedge clk);
    check("pending_expected", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
